// File: rtl/core_lsu_sequencer.sv
//------------------------------------------------------------------------------
// Module   : core_lsu_sequencer
// Purpose  : Load/store execution stage. Accepts one LSU request from the
//            decoder, runs a single TOY memory access (load, store, load
//            indirect, store indirect) over a req/gnt/rvalid data-memory
//            handshake, writes load results into the register file and
//            pulses done_o on completion.
// Ports    : clk_i/rst_ni          clock, async active-low reset
//            req_i..wdata_i        request and operands from decoder
//            ready_o               idle, request will be accepted
//            mem_*                 data-memory handshake
//            arf_*                 register-file write port
//            done_o                one-cycle completion pulse
//            stdin_*/stdout_*      stdio ports (TOY_LSU_STDIO_EN only)
// Options  : TOY_LSU_STDIO_EN - accesses to IO_ADDR go to stdio ports
//            instead of memory.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module core_lsu_sequencer #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter logic [ADDR_W-1:0] IO_ADDR = 8'hFF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_i,
    input  logic              wen_i,
    input  logic              kind_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] rt_val_i,
    input  logic [3:0]        rd_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              ready_o,
    output logic              mem_req_o,
    output logic              mem_wen_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              arf_wen_o,
    output logic [3:0]        arf_waddr_o,
    output logic [DATA_W-1:0] arf_wdata_o,
`ifdef TOY_LSU_STDIO_EN
    input  logic              stdin_valid_i,
    input  logic [DATA_W-1:0] stdin_data_i,
    output logic              stdin_ready_o,
    output logic              stdout_valid_o,
    output logic [DATA_W-1:0] stdout_data_o,
    input  logic              stdout_ready_i,
`endif
    output logic              done_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ    = 3'd1,
        S_WAIT   = 3'd2,
        S_WB     = 3'd3
`ifdef TOY_LSU_STDIO_EN
        ,
        S_STDIN  = 3'd4,
        S_STDOUT = 3'd5
`endif
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_wen;
    logic [ADDR_W-1:0]   r_addr;
    logic [3:0]          r_rd;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_done;

    logic [ADDR_W-1:0]   w_req_addr;
    logic                w_done_nxt;
    logic                w_capture;
    logic [DATA_W-1:0]   w_capture_data;

    // Indirect addressing uses only the low ADDR_W bits of R[t].
    assign w_req_addr = kind_i ? addr_i : rt_val_i[ADDR_W-1:0];

    logic w_unused_rt;
    assign w_unused_rt = &{1'b0, rt_val_i[DATA_W-1:ADDR_W]};

`ifndef TOY_LSU_STDIO_EN
    logic w_unused_io;
    assign w_unused_io = (r_addr == IO_ADDR);
`endif

    //--------------------------------------------------------------------------
    // Next-state and completion logic
    //--------------------------------------------------------------------------
    always_comb begin
        w_next         = r_state;
        w_done_nxt     = 1'b0;
        w_capture      = 1'b0;
        w_capture_data = mem_rdata_i;
        case (r_state)
            S_IDLE: begin
                if (req_i) begin
`ifdef TOY_LSU_STDIO_EN
                    if (w_req_addr == IO_ADDR) begin
                        w_next = wen_i ? S_STDOUT : S_STDIN;
                    end else begin
                        w_next = S_REQ;
                    end
`else
                    w_next = S_REQ;
`endif
                end
            end
            S_REQ: begin
                if (mem_gnt_i) begin
                    // Stores complete on grant; loads still need read data.
                    w_next     = r_wen ? S_IDLE : S_WAIT;
                    w_done_nxt = r_wen;
                end
            end
            S_WAIT: begin
                if (mem_rvalid_i) begin
                    w_next     = S_WB;
                    w_capture  = 1'b1;
                    w_done_nxt = 1'b1;
                end
            end
            S_WB: begin
                w_next = S_IDLE;
            end
`ifdef TOY_LSU_STDIO_EN
            S_STDIN: begin
                w_capture_data = stdin_data_i;
                if (stdin_valid_i) begin
                    w_next     = S_WB;
                    w_capture  = 1'b1;
                    w_done_nxt = 1'b1;
                end
            end
            S_STDOUT: begin
                if (stdout_ready_i) begin
                    w_next     = S_IDLE;
                    w_done_nxt = 1'b1;
                end
            end
`endif
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // State and operand registers
    //--------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_wen   <= 1'b0;
            r_addr  <= '0;
            r_rd    <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            // done_o is registered so that it lands in the cycle after the
            // finishing handshake: IDLE for stores, WB for loads.
            r_done  <= w_done_nxt;
            if (r_state == S_IDLE && req_i) begin
                r_wen   <= wen_i;
                r_addr  <= w_req_addr;
                r_rd    <= rd_i;
                r_wdata <= wdata_i;
            end
            if (w_capture) begin
                r_rdata <= w_capture_data;
            end
        end
    end

    //--------------------------------------------------------------------------
    // Outputs
    //--------------------------------------------------------------------------
    assign ready_o     = (r_state == S_IDLE);
    assign mem_req_o   = (r_state == S_REQ);
    assign mem_wen_o   = (r_state == S_REQ) && r_wen;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;
    assign arf_wen_o   = (r_state == S_WB) && (r_rd != 4'd0);
    assign arf_waddr_o = (r_state == S_WB) ? r_rd : 4'd0;
    assign arf_wdata_o = (r_state == S_WB) ? r_rdata : '0;
    assign done_o      = r_done;

`ifdef TOY_LSU_STDIO_EN
    assign stdin_ready_o  = (r_state == S_STDIN);
    assign stdout_valid_o = (r_state == S_STDOUT);
    assign stdout_data_o  = (r_state == S_STDOUT) ? r_wdata : '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_core_lsu_sequencer.sv
//------------------------------------------------------------------------------
// Module   : tb_core_lsu_sequencer
// Purpose  : Directed self-checking bench for core_lsu_sequencer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_core_lsu_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_i = 1'b0;
    logic        wen_i = 1'b0;
    logic        kind_i = 1'b0;
    logic [7:0]  addr_i = '0;
    logic [15:0] rt_val_i = '0;
    logic [3:0]  rd_i = '0;
    logic [15:0] wdata_i = '0;
    logic        ready_o;
    logic        mem_req_o;
    logic        mem_wen_o;
    logic [7:0]  mem_addr_o;
    logic [15:0] mem_wdata_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [15:0] mem_rdata_i = '0;
    logic        arf_wen_o;
    logic [3:0]  arf_waddr_o;
    logic [15:0] arf_wdata_o;
    logic        done_o;
`ifdef TOY_LSU_STDIO_EN
    logic        stdin_valid_i = 1'b0;
    logic [15:0] stdin_data_i = '0;
    logic        stdin_ready_o;
    logic        stdout_valid_o;
    logic [15:0] stdout_data_o;
    logic        stdout_ready_i = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    core_lsu_sequencer dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_i        (req_i),
        .wen_i        (wen_i),
        .kind_i       (kind_i),
        .addr_i       (addr_i),
        .rt_val_i     (rt_val_i),
        .rd_i         (rd_i),
        .wdata_i      (wdata_i),
        .ready_o      (ready_o),
        .mem_req_o    (mem_req_o),
        .mem_wen_o    (mem_wen_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .arf_wen_o    (arf_wen_o),
        .arf_waddr_o  (arf_waddr_o),
        .arf_wdata_o  (arf_wdata_o),
`ifdef TOY_LSU_STDIO_EN
        .stdin_valid_i  (stdin_valid_i),
        .stdin_data_i   (stdin_data_i),
        .stdin_ready_o  (stdin_ready_o),
        .stdout_valid_o (stdout_valid_o),
        .stdout_data_o  (stdout_data_o),
        .stdout_ready_i (stdout_ready_i),
`endif
        .done_o       (done_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit past the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---------------- reset ----------------
        #2;
        chk("rst_ready", ready_o, 1);
        chk("rst_mem_req", mem_req_o, 0);
        chk("rst_mem_wen", mem_wen_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_mem_wdata", mem_wdata_o, 0);
        chk("rst_arf_wen", arf_wen_o, 0);
        chk("rst_arf_wdata", arf_wdata_o, 0);
        chk("rst_done", done_o, 0);
        tick();
        rst_ni = 1'b1;
        tick();

        // ---------------- direct load R3 <- [0x10] ----------------
        req_i = 1; wen_i = 0; kind_i = 1; addr_i = 8'h10; rd_i = 4'd3;
        chk("ld_c0_ready", ready_o, 1);
        tick();                                   // cycle 1: REQ
        req_i = 0;
        chk("ld_c1_mem_req", mem_req_o, 1);
        chk("ld_c1_mem_wen", mem_wen_o, 0);
        chk("ld_c1_mem_addr", mem_addr_o, 8'h10);
        chk("ld_c1_ready", ready_o, 0);
        mem_gnt_i = 1;
        tick();                                   // cycle 2: WAIT
        mem_gnt_i = 0;
        chk("ld_c2_mem_req", mem_req_o, 0);
        chk("ld_c2_done", done_o, 0);
        mem_rvalid_i = 1; mem_rdata_i = 16'hBEEF;
        tick();                                   // cycle 3: WB
        mem_rvalid_i = 0; mem_rdata_i = 16'h0;
        chk("ld_c3_arf_wen", arf_wen_o, 1);
        chk("ld_c3_arf_waddr", arf_waddr_o, 4'd3);
        chk("ld_c3_arf_wdata", arf_wdata_o, 16'hBEEF);
        chk("ld_c3_done", done_o, 1);
        chk("ld_c3_ready", ready_o, 0);
        tick();                                   // cycle 4: IDLE
        chk("ld_c4_ready", ready_o, 1);
        chk("ld_c4_done", done_o, 0);
        chk("ld_c4_arf_wen", arf_wen_o, 0);

        // ---------------- indirect store [0x34] <- 0x00AA, gnt delayed 3 ----------------
        req_i = 1; wen_i = 1; kind_i = 0; addr_i = 8'h77; rt_val_i = 16'h1234;
        wdata_i = 16'h00AA; rd_i = 4'd5;
        tick();                                   // first REQ cycle
        req_i = 0; wdata_i = 16'h5A5A; rt_val_i = 16'h0;
        for (int i = 0; i < 3; i++) begin
            chk("st_wait_mem_req", mem_req_o, 1);
            chk("st_wait_mem_wen", mem_wen_o, 1);
            chk("st_wait_mem_addr", mem_addr_o, 8'h34);
            chk("st_wait_mem_wdata", mem_wdata_o, 16'h00AA);
            chk("st_wait_done", done_o, 0);
            chk("st_wait_arf_wen", arf_wen_o, 0);
            tick();
        end
        chk("st_gnt_mem_req", mem_req_o, 1);
        mem_gnt_i = 1;
        tick();
        mem_gnt_i = 0;
        chk("st_done", done_o, 1);
        chk("st_done_mem_req", mem_req_o, 0);
        chk("st_done_arf_wen", arf_wen_o, 0);
        chk("st_done_ready", ready_o, 1);
        tick();
        chk("st_done_pulse_end", done_o, 0);
        chk("st_after_arf_wen", arf_wen_o, 0);

        // ---------------- load to R0 ----------------
        req_i = 1; wen_i = 0; kind_i = 1; addr_i = 8'h20; rd_i = 4'd0;
        tick();
        req_i = 0; mem_gnt_i = 1;
        chk("r0_mem_addr", mem_addr_o, 8'h20);
        tick();
        mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 16'hFFFF;
        tick();
        mem_rvalid_i = 0;
        chk("r0_done", done_o, 1);
        chk("r0_arf_wen", arf_wen_o, 0);
        tick();
        chk("r0_ready", ready_o, 1);

        // ---------------- busy request ignored, stray responses ----------------
        req_i = 1; wen_i = 0; kind_i = 1; addr_i = 8'h30; rd_i = 4'd7;
        tick();                                   // REQ
        req_i = 0; mem_gnt_i = 1;
        tick();                                   // WAIT
        mem_gnt_i = 0;
        req_i = 1; wen_i = 1; addr_i = 8'h40; rd_i = 4'd8;
        chk("busy_ready", ready_o, 0);
        tick();                                   // still WAIT
        req_i = 0;
        chk("busy_no_new_req", mem_req_o, 0);
        chk("busy_addr_kept", mem_addr_o, 8'h30);
        mem_rvalid_i = 1; mem_rdata_i = 16'h5555;
        tick();                                   // WB
        mem_rvalid_i = 0;
        chk("busy_wb_waddr", arf_waddr_o, 4'd7);
        chk("busy_wb_wdata", arf_wdata_o, 16'h5555);
        tick();                                   // IDLE
        chk("busy_idle_ready", ready_o, 1);
        chk("busy_idle_no_req", mem_req_o, 0);
        mem_rvalid_i = 1; mem_rdata_i = 16'h1111; mem_gnt_i = 1;
        tick();
        mem_rvalid_i = 0; mem_gnt_i = 0;
        chk("stray_arf_wen", arf_wen_o, 0);
        chk("stray_done", done_o, 0);
        chk("stray_ready", ready_o, 1);
        chk("stray_mem_req", mem_req_o, 0);

        // ---------------- reset during WAIT ----------------
        req_i = 1; wen_i = 0; kind_i = 1; addr_i = 8'h50; rd_i = 4'd9;
        tick();
        req_i = 0; mem_gnt_i = 1;
        tick();                                   // WAIT
        mem_gnt_i = 0;
        chk("mrst_pre_ready", ready_o, 0);
        rst_ni = 0;
        #1;
        chk("mrst_ready", ready_o, 1);
        chk("mrst_mem_addr", mem_addr_o, 0);
        chk("mrst_done", done_o, 0);
        chk("mrst_arf_wen", arf_wen_o, 0);
        tick();
        rst_ni = 1;
        mem_rvalid_i = 1; mem_rdata_i = 16'hDEAD;
        tick();
        mem_rvalid_i = 0;
        chk("mrst_late_arf_wen", arf_wen_o, 0);
        chk("mrst_late_done", done_o, 0);
        chk("mrst_late_ready", ready_o, 1);

`ifdef TOY_LSU_STDIO_EN
        // ---------------- stdout store ----------------
        req_i = 1; wen_i = 1; kind_i = 1; addr_i = 8'hFF; wdata_i = 16'h0041;
        tick();
        req_i = 0;
        for (int i = 0; i < 3; i++) begin
            chk("io_valid", stdout_valid_o, 1);
            chk("io_data", stdout_data_o, 16'h0041);
            chk("io_mem_req", mem_req_o, 0);
            chk("io_done_early", done_o, 0);
            if (i == 2) stdout_ready_i = 1;
            tick();
        end
        stdout_ready_i = 0;
        chk("io_valid_drop", stdout_valid_o, 0);
        chk("io_done", done_o, 1);
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/core_lsu_sequencer.md
Name: core_lsu_sequencer

Overview:
- Load/store execution stage directly downstream of the instruction decoder.
- Consumes the decoder's preempt LSU request (en/wen/kind) plus operands and runs one TOY memory access: load, store, load indirect or store indirect.
- Drives the data-memory handshake and writes load results into the architectural register file.
- Pulses done_o so the issue logic can clear the stall and the destination dirty bit.

Parameters:
- ADDR_W, 8, memory address width.
- DATA_W, 16, data and register width.
- IO_ADDR, 8'hFF, address mapped to stdio when TOY_LSU_STDIO_EN is defined.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset, asynchronous, active-low.
- req_i  input  1  LSU request (decoder lsu_en); accepted only when ready_o=1.
- wen_i  input  1  1: store, 0: load.
- kind_i  input  1  1: direct address from addr_i; 0: indirect address from rt_val_i[ADDR_W-1:0].
- addr_i  input  ADDR_W  direct address (instr[7:0]).
- rt_val_i  input  DATA_W  R[t] value.
- rd_i  input  4  destination or source register index.
- wdata_i  input  DATA_W  R[d] value for stores.
- ready_o  output  1  idle, can accept req_i.
- mem_req_o  output  1  memory request valid.
- mem_wen_o  output  1  memory write enable.
- mem_addr_o  output  ADDR_W  memory address.
- mem_wdata_o  output  DATA_W  memory write data.
- mem_gnt_i  input  1  memory accepted request.
- mem_rvalid_i  input  1  read data valid.
- mem_rdata_i  input  DATA_W  read data.
- arf_wen_o  output  1  register-file write enable.
- arf_waddr_o  output  4  register-file write index.
- arf_wdata_o  output  DATA_W  register-file write data.
- done_o  output  1  one-cycle completion pulse.

Behaviour:
- Reset values: all outputs 0 except ready_o=1; state IDLE; operand registers cleared.
- States: IDLE, REQ, WAIT, WB.
- IDLE: ready_o=1. When req_i=1, register wen/address/rd/wdata and go to REQ. Address mux: kind_i ? addr_i : rt_val_i[ADDR_W-1:0]; upper bits of rt_val_i are ignored.
- REQ: mem_req_o=1 with stable wen/addr/wdata until mem_gnt_i=1.
  - Store granted: go to IDLE and pulse done_o for one cycle.
  - Load granted: go to WAIT.
- WAIT: mem_rvalid_i is sampled only in this state. Memory guarantees rvalid at least one cycle after gnt. On rvalid, capture rdata and go to WB.
- WB: arf_wen_o=(rd!=0), arf_waddr_o=rd, arf_wdata_o=captured data, done_o=1. Next state IDLE.
- R0 is never written; done_o is still pulsed.
- Minimum latency (req at cycle 0, gnt on first REQ cycle):
  - Store: mem_req_o in cycle 1, done_o in cycle 2.
  - Load: rvalid in cycle 2, WB/done_o in cycle 3.
- ready_o=0 from the cycle after acceptance until state returns to IDLE. req_i while busy is ignored, with no queueing.
- Back-to-back: a new req_i is accepted in the first IDLE cycle after done_o.
- mem_rvalid_i or mem_gnt_i arriving in IDLE is ignored.
- Reset asserted mid-operation: immediate return to IDLE with outputs at reset values. Late memory responses are discarded.
- No timeout: the block waits on gnt/rvalid indefinitely.

Optional Feature:
- Macro: TOY_LSU_STDIO_EN.
- Defined: accesses to IO_ADDR bypass memory and use extra ports:
  - stdin_valid_i  input  1
  - stdin_data_i  input  DATA_W
  - stdin_ready_o  output  1
  - stdout_valid_o  output  1
  - stdout_data_o  output  DATA_W
  - stdout_ready_i  input  1
- Load from IO_ADDR: state STDIN. stdin_ready_o=1 until stdin_valid_i, then capture data and go to WB.
- Store to IO_ADDR: state STDOUT. stdout_valid_o=1 with stdout_data_o=wdata until stdout_ready_i, then done_o.
- mem_req_o stays 0 for stdio accesses.
- Not defined: IO_ADDR is ordinary memory; stdio ports and states are absent.

Test Plan:
- Direct load: req_i=1, wen=0, kind=1, addr=8'h10, rd=3; gnt immediate; rvalid next cycle with 16'hBEEF -> mem_addr_o=8'h10, arf write R3=16'hBEEF and done_o in cycle 3; ready_o returns to 1 in cycle 4.
- Indirect store: kind=0, rt_val=16'h1234, wdata=16'h00AA, rd=5; gnt held off 3 cycles -> mem_addr_o=8'h34, wdata stable while waiting; done_o one cycle after gnt; arf_wen_o never asserted.
- Load to R0: rd=0, rdata=16'hFFFF -> done_o=1, arf_wen_o=0.
- Busy and stray signals: second req_i during WAIT is ignored, with exactly one mem_req_o transaction; rvalid pulse in IDLE produces no arf write.
- Reset mid-op: rst_ni low while in WAIT -> outputs reset asynchronously; rvalid after release does not write the register file; ready_o=1.
- TOY_LSU_STDIO_EN store: store to 8'hFF with wdata 16'h0041, stdout_ready_i delayed 2 cycles -> stdout_valid_o high 3 cycles, mem_req_o=0, done_o after the handshake.
